// File: rtl/dsp_config_loader_if.sv
// Word handshake between the config host/memory and the loader.
// The host drives data/valid; the loader answers with ready.
interface dsp_config_loader_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/dsp_config_loader.sv
// Serial writer for the DSP configuration chain: takes parallel words
// and shifts exactly CFG_BITS bits out LSB-first, then pulses done.
module dsp_config_loader #(
    parameter int CFG_BITS = 100,
    parameter int WORD_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    dsp_config_loader_if.slave   wr,
    output logic                 cfg_out,
    output logic                 cfg_en,
    output logic                 busy,
    output logic                 done
);
    localparam int BW = $clog2(CFG_BITS + 1);
    localparam int IW = $clog2(WORD_W + 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] sh;
    logic [BW-1:0]     bit_cnt;
    logic [IW-1:0]     idx;
    logic              ready_q;

    assign wr.word_ready = ready_q;

    // bit_cnt is the index of the bit on cfg_out while shifting,
    // and the index of the next bit to send while stalled in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sh      <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            ready_q <= 1'b0;
            cfg_out <= 1'b0;
            cfg_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state   <= S_LOAD;
                        busy    <= 1'b1;
                        ready_q <= 1'b1;
                        bit_cnt <= '0;
                        idx     <= '0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b0;
                        cfg_en  <= 1'b0;
                        cfg_out <= 1'b0;
                        busy    <= 1'b0;
                    end else if (wr.word_valid) begin
                        state   <= S_SHIFT;
                        ready_q <= 1'b0;
                        cfg_en  <= 1'b1;
                        cfg_out <= wr.word_data[0];
                        sh      <= wr.word_data >> 1;
                        idx     <= '0;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b0;
                        cfg_en  <= 1'b0;
                        cfg_out <= 1'b0;
                        busy    <= 1'b0;
                    end else if (bit_cnt == LAST_BIT) begin
                        state   <= S_DONE;
                        ready_q <= 1'b0;
                        cfg_en  <= 1'b0;
                        cfg_out <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (idx == LAST_IDX) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (wr.word_valid) begin
                            // seamless hand-over to the next word
                            ready_q <= 1'b0;
                            cfg_out <= wr.word_data[0];
                            sh      <= wr.word_data >> 1;
                            idx     <= '0;
                        end else begin
                            state   <= S_LOAD;
                            cfg_en  <= 1'b0;
                            cfg_out <= 1'b0;
                        end
                    end else begin
                        cfg_out <= sh[0];
                        sh      <= sh >> 1;
                        idx     <= idx + 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                        ready_q <= ((idx + 1'b1) == LAST_IDX)
                                && ((bit_cnt + 1'b1) != LAST_BIT);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_config_loader.sv
// Directed bench for dsp_config_loader: main 100/16 instance plus
// 16-bit and 1-bit chain instances for the edge configurations.
module tb_dsp_config_loader;
    logic clk = 1'b0;
    logic rst_n;
    logic start, abort;
    logic cfg_out, cfg_en, busy, done;
    logic start16, cfg_out16, cfg_en16, busy16, done16;
    logic start1, cfg_out1, cfg_en1, busy1, done1;
    logic no_abort;

    int n_checks = 0;
    int n_fail   = 0;

    int n_acc, n_en, n_gap, max_run, n_done, bit_err, done_gap, first_en;
    bit timed_out, aborted;
    logic [15:0] rec16;

    logic [15:0] words [7];

    always #5 clk = ~clk;

    dsp_config_loader_if #(.WORD_W(16)) bus ();
    dsp_config_loader_if #(.WORD_W(16)) bus16 ();
    dsp_config_loader_if #(.WORD_W(16)) bus1 ();

    dsp_config_loader #(.CFG_BITS(100), .WORD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .wr(bus), .cfg_out(cfg_out), .cfg_en(cfg_en),
        .busy(busy), .done(done)
    );

    dsp_config_loader #(.CFG_BITS(16), .WORD_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .abort(no_abort),
        .wr(bus16), .cfg_out(cfg_out16), .cfg_en(cfg_en16),
        .busy(busy16), .done(done16)
    );

    dsp_config_loader #(.CFG_BITS(1), .WORD_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(no_abort),
        .wr(bus1), .cfg_out(cfg_out1), .cfg_en(cfg_en1),
        .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one session on the main instance and records statistics.
    task automatic drive(input bit gap, input int abort_bit, input bit pulse);
        int wi, nb, hold, run, last_en;
        bit acc, gap_done, pulsed;
        wi = 0; nb = 0; hold = 0; run = 0; last_en = -100;
        gap_done = 0; pulsed = 0;
        n_acc = 0; n_en = 0; n_gap = 0; max_run = 0; n_done = 0;
        bit_err = 0; done_gap = -1; first_en = -1;
        timed_out = 1; aborted = 0; rec16 = '0;
        start = 1'b1;
        bus.word_valid = 1'b1;
        bus.word_data = words[0];
        for (int cyc = 0; cyc < 400; cyc++) begin
            acc = bus.word_valid && bus.word_ready;
            tick();
            start = 1'b0;
            if (abort) begin
                abort = 1'b0; aborted = 1; timed_out = 0;
                break;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) bus.word_valid = 1'b1;
            end
            if (acc) begin
                n_acc++; wi++;
                if (wi < 7) bus.word_data = words[wi];
            end
            if (gap && wi == 2 && !gap_done && bus.word_ready) begin
                bus.word_valid = 1'b0; hold = 5; gap_done = 1;
            end
            if (cfg_en) begin
                if (nb < 100) begin
                    if (cfg_out !== words[nb/16][nb%16]) bit_err++;
                end else bit_err++;
                if (nb < 16) rec16[nb] = cfg_out;
                nb++; n_en++; run++;
                if (run > max_run) max_run = run;
                last_en = cyc;
                if (first_en < 0) first_en = cyc;
            end else begin
                run = 0;
                if (first_en >= 0 && !done) n_gap++;
            end
            if (done) begin
                n_done++; done_gap = cyc - last_en; timed_out = 0;
                break;
            end
            if (abort_bit >= 0 && nb == abort_bit + 1) abort = 1'b1;
            if (pulse && nb == 20 && !pulsed) begin
                start = 1'b1; pulsed = 1;
            end
        end
        bus.word_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({cfg_en, cfg_out, busy, done, bus.word_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b expected 00000",
                     {cfg_en, cfg_out, busy, done, bus.word_ready});
        end
        rst_n = 1'b1;
        bus.word_valid = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({cfg_en, busy, bus.word_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: got %b expected 000",
                     {cfg_en, busy, bus.word_ready});
        end
        bus.word_valid = 1'b0;
    endtask

    task automatic test_stream();
        drive(1'b0, -1, 1'b0);
        n_checks++;
        if (timed_out !== 1'b0) begin n_fail++; $display("FAIL stream_timeout: got %0d expected 0", timed_out); end
        n_checks++;
        if (n_acc !== 7) begin n_fail++; $display("FAIL stream_words: got %0d expected 7", n_acc); end
        n_checks++;
        if (n_en !== 100) begin n_fail++; $display("FAIL stream_en_total: got %0d expected 100", n_en); end
        n_checks++;
        if (max_run !== 100) begin n_fail++; $display("FAIL stream_en_run: got %0d expected 100", max_run); end
        n_checks++;
        if (bit_err !== 0) begin n_fail++; $display("FAIL stream_bits: got %0d errors expected 0", bit_err); end
        n_checks++;
        if (rec16 !== 16'b1010_0101_1100_0011) begin n_fail++; $display("FAIL a5c3_seq: got %h expected a5c3", rec16); end
        n_checks++;
        if (first_en !== 1) begin n_fail++; $display("FAIL first_en_lat: got %0d expected 1", first_en); end
        n_checks++;
        if (n_done !== 1 || done_gap !== 1) begin n_fail++; $display("FAIL stream_done: got n=%0d gap=%0d expected n=1 gap=1", n_done, done_gap); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b expected 0", busy); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b expected 0", done); end
    endtask

    task automatic test_stall();
        drive(1'b1, -1, 1'b0);
        n_checks++;
        if (n_gap !== 5) begin n_fail++; $display("FAIL stall_gap: got %0d expected 5", n_gap); end
        n_checks++;
        if (n_en !== 100) begin n_fail++; $display("FAIL stall_en_total: got %0d expected 100", n_en); end
        n_checks++;
        if (bit_err !== 0) begin n_fail++; $display("FAIL stall_bits: got %0d errors expected 0", bit_err); end
        n_checks++;
        if (n_acc !== 7 || n_done !== 1) begin n_fail++; $display("FAIL stall_words_done: got acc=%0d done=%0d expected 7/1", n_acc, n_done); end
        tick();
    endtask

    task automatic test_abort();
        drive(1'b0, 40, 1'b1);
        n_checks++;
        if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_seen: got %0d expected 1", aborted); end
        n_checks++;
        if (n_en !== 41 || bit_err !== 0) begin n_fail++; $display("FAIL abort_bits: got en=%0d err=%0d expected 41/0", n_en, bit_err); end
        n_checks++;
        if ({cfg_en, busy, done, bus.word_ready} !== 4'b0) begin n_fail++; $display("FAIL abort_outs: got %b expected 0000", {cfg_en, busy, done, bus.word_ready}); end
        begin
            int seen = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (done || busy || cfg_en) seen++;
            end
            n_checks++;
            if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
        end
        drive(1'b0, -1, 1'b0);
        n_checks++;
        if (n_en !== 100 || bit_err !== 0 || n_done !== 1) begin n_fail++; $display("FAIL restart_full: got en=%0d err=%0d done=%0d expected 100/0/1", n_en, bit_err, n_done); end
        tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        bus.word_valid = 1'b1;
        bus.word_data = words[0];
        tick();
        start = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (cfg_en !== 1'b1) begin n_fail++; $display("FAIL mid_shift_en: got %b expected 1", cfg_en); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cfg_en, bus.word_ready, busy, done} !== 4'b0) begin n_fail++; $display("FAIL async_reset: got %b expected 0000", {cfg_en, bus.word_ready, busy, done}); end
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        n_checks++;
        if ({cfg_en, bus.word_ready, busy} !== 3'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 000", {cfg_en, bus.word_ready, busy}); end
        bus.word_valid = 1'b0;
    endtask

    task automatic test_edge16();
        int accn, en, extra;
        bit acc, dn;
        logic [15:0] got;
        accn = 0; en = 0; extra = 0; dn = 0; got = '0;
        start16 = 1'b1;
        bus16.word_valid = 1'b1;
        bus16.word_data = 16'h1234;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = bus16.word_valid && bus16.word_ready;
            tick();
            start16 = 1'b0;
            if (acc) accn++;
            if (accn > 0 && bus16.word_ready) extra++;
            if (cfg_en16) begin
                if (en < 16) got[en] = cfg_out16;
                en++;
            end
            if (done16) begin dn = 1; break; end
        end
        bus16.word_valid = 1'b0;
        n_checks++;
        if (accn !== 1 || extra !== 0) begin n_fail++; $display("FAIL edge16_ready: got acc=%0d extra=%0d expected 1/0", accn, extra); end
        n_checks++;
        if (en !== 16 || got !== 16'h1234) begin n_fail++; $display("FAIL edge16_bits: got en=%0d data=%h expected 16/1234", en, got); end
        n_checks++;
        if (dn !== 1'b1) begin n_fail++; $display("FAIL edge16_done: got %0d expected 1", dn); end
    endtask

    task automatic test_edge1();
        int accn, en, en_cyc, dn_cyc;
        bit acc;
        logic bitv;
        accn = 0; en = 0; en_cyc = -1; dn_cyc = -1; bitv = 1'b0;
        start1 = 1'b1;
        bus1.word_valid = 1'b1;
        bus1.word_data = 16'h5555;
        for (int cyc = 0; cyc < 30; cyc++) begin
            acc = bus1.word_valid && bus1.word_ready;
            tick();
            start1 = 1'b0;
            if (acc) accn++;
            if (cfg_en1) begin en++; en_cyc = cyc; bitv = cfg_out1; end
            if (done1) begin dn_cyc = cyc; break; end
        end
        bus1.word_valid = 1'b0;
        n_checks++;
        if (en !== 1 || bitv !== 1'b1) begin n_fail++; $display("FAIL edge1_bit: got en=%0d bit=%b expected 1/1", en, bitv); end
        n_checks++;
        if (dn_cyc < 0 || dn_cyc - en_cyc !== 1) begin n_fail++; $display("FAIL edge1_done: got done=%0d en=%0d expected done=en+1", dn_cyc, en_cyc); end
        n_checks++;
        if (accn !== 1) begin n_fail++; $display("FAIL edge1_words: got %0d expected 1", accn); end
    endtask

    initial begin
        words[0] = 16'hA5C3;
        words[1] = 16'h1234;
        words[2] = 16'hBEEF;
        words[3] = 16'h0F0F;
        words[4] = 16'h8001;
        words[5] = 16'h7E5A;
        words[6] = 16'hFFF9;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; no_abort = 1'b0;
        start16 = 1'b0; start1 = 1'b0;
        bus.word_valid = 1'b0; bus.word_data = '0;
        bus16.word_valid = 1'b0; bus16.word_data = '0;
        bus1.word_valid = 1'b0; bus1.word_data = '0;
        test_reset();
        test_stream();
        test_stall();
        test_abort();
        test_reset_mid();
        test_edge16();
        test_edge1();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
